sfifo_mark: RTL and testbench
=============================

# sfifo_mark

Single-clock, parametrised FIFO with programmable almost-full/almost-empty thresholds, level count, sticky error flags and a read-pointer mark/rewind facility for packet replay. It generalises the fixed 9-bit FIFO wrapper: any width and power-of-two depth, and a working read-pointer reset. That reset becomes "rewind to last mark", which lets a consumer (DMA/TLP builder) re-read a packet after a retry without the producer resending it. Sits between a same-clock producer and consumer in the PCIe DMA datapath.

## Interface
- DATA_WIDTH, 9, word width in bits
- ADDRESS_WIDTH, 10, log2 of depth; DEPTH = 2**ADDRESS_WIDTH
- AF_MARGIN, 4, almost_full when committed occupancy >= DEPTH - AF_MARGIN
- AE_LEVEL, 4, almost_empty when count <= AE_LEVEL

- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  synchronous reset, active-low
- din  in  DATA_WIDTH  write data
- wr_en  in  1  write request
- full  out  1  no free slot (measured against mark pointer)
- dout  out  DATA_WIDTH  read data, registered
- rd_en  in  1  read request
- empty  out  1  no unread word
- count  out  ADDRESS_WIDTH+1  unread words, wr_ptr - rd_ptr
- almost_full  out  1  see AF_MARGIN
- almost_empty  out  1  see AE_LEVEL
- mark  in  1  commit: read data up to the current read pointer is released
- rewind  in  1  restore read pointer to last mark
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Pointers wr_ptr, rd_ptr, mk_ptr: ADDRESS_WIDTH+1 bits, modulo-2^(ADDRESS_WIDTH+1) arithmetic, low ADDRESS_WIDTH bits address storage; wrap is natural.
- Occupancy used = wr_ptr - mk_ptr governs full/almost_full. Read words are not reusable until marked.
- full = (used == DEPTH); empty = (wr_ptr == rd_ptr). Both are combinational from registered pointers.
- Write accepted iff wr_en && !full: mem[wr_ptr] <= din, wr_ptr++. wr_en && full: dropped, overflow <= 1.
- Read accepted iff rd_en && !empty && !rewind: dout <= mem[rd_ptr], rd_ptr++. rd_en && empty (and !rewind): dout holds, underflow <= 1.
- rewind: rd_ptr <= mk_ptr. It has priority over rd_en and mark; both are ignored that cycle (no underflow set).
- mark (no rewind): mk_ptr <= rd_ptr value after this cycle's read (rd_ptr+1 if a read is accepted the same cycle).
- Simultaneous write+read: both act. A read does not free space for a same-cycle write. The full decision uses pre-edge pointers.
- Write while empty plus read the same cycle: read is rejected (empty), underflow set.
- Sticky flags clear only on reset.
- rst_n=0 at clk edge: all pointers 0, dout 0, overflow/underflow 0. Mid-operation reset discards contents. Memory array is not cleared.

## Timing
- Reset values of outputs: full 0, empty 1, count 0, almost_full 0 (for AF_MARGIN < DEPTH), almost_empty 1, dout 0, overflow 0, underflow 0.
- Read latency 1: dout valid the cycle after the edge at which rd_en was accepted. No first-word-fall-through.
- Write-to-empty-deassert: 1 cycle (empty low after the accepting edge). A word written at edge N is readable by rd_en sampled at edge N+1.
- All status outputs reflect pointer state after the most recent edge. No extra pipeline.
- Storage: synchronous-read RAM inferable as block RAM. No read-during-write hazard, since a slot being written is never unread.

## Test plan
- Config DATA_WIDTH=9, ADDRESS_WIDTH=4 (DEPTH 16), AF_MARGIN=4, AE_LEVEL=4. Reset -> full 0, empty 1, count 0, almost_empty 1, almost_full 0, dout 0, flags 0.
- Fill and drain: write 0x100..0x10F, mark every read cycle -> almost_full from 12th write, full after 16th, count 16. 17th write dropped, overflow=1. 16 reads -> dout 0x100..0x10F in order, empty after last. Extra read -> underflow=1, dout stays 0x10F.
- Replay: write 8 words 0x0A0..0x0A7, read 5 without mark (dout 0x0A0..0x0A4, count 3), pulse rewind -> count 8. Next reads return 0x0A0 onward.
- Mark frees space: write 16 (full), read 3 with mark on 3rd read -> full deasserts next cycle. Exactly 3 more writes accepted, 4th sets overflow.
- Collisions: rd_en+rewind same cycle -> rd_ptr = mk_ptr, dout unchanged, no underflow. mark+rewind -> mk_ptr unchanged. wr_en+rd_en at full with no mark -> write dropped, read accepted, count 15.
- Mid-operation reset: with count 7 and overflow set, drive rst_n=0 for one edge -> all outputs at reset values next cycle. Subsequent write/read of 0x1FF returns 0x1FF.

Source files
------------

// File: rtl/sfifo_mark_if.sv
// Producer/consumer-facing signal bundle of sfifo_mark.
// The FIFO takes the slave modport; the attached datapath takes the master modport.
interface sfifo_mark_if #(
    parameter int unsigned DATA_WIDTH    = 9,
    parameter int unsigned ADDRESS_WIDTH = 10
);
    logic [DATA_WIDTH-1:0]  din;
    logic                   wr_en;
    logic                   full;
    logic [DATA_WIDTH-1:0]  dout;
    logic                   rd_en;
    logic                   empty;
    logic [ADDRESS_WIDTH:0] count;
    logic                   almost_full;
    logic                   almost_empty;
    logic                   mark;
    logic                   rewind;
    logic                   overflow;
    logic                   underflow;

    modport master (
        output din, wr_en, rd_en, mark, rewind,
        input  full, dout, empty, count, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  din, wr_en, rd_en, mark, rewind,
        output full, dout, empty, count, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/sfifo_mark.sv
// Single-clock FIFO with a read-pointer mark/rewind for packet replay.
// Space is only released back to the writer once read data has been marked.
module sfifo_mark #(
    parameter int unsigned DATA_WIDTH    = 9,
    parameter int unsigned ADDRESS_WIDTH = 10,
    parameter int unsigned AF_MARGIN     = 4,
    parameter int unsigned AE_LEVEL      = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    sfifo_mark_if.slave    bus
);
    localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_P   = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [ADDRESS_WIDTH:0] AF_THRESH = DEPTH_P - (ADDRESS_WIDTH+1)'(AF_MARGIN);
    localparam logic [ADDRESS_WIDTH:0] AE_THRESH = (ADDRESS_WIDTH+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [ADDRESS_WIDTH:0] wr_ptr;
    logic [ADDRESS_WIDTH:0] rd_ptr;
    logic [ADDRESS_WIDTH:0] mk_ptr;
    logic [ADDRESS_WIDTH:0] rd_next;
    logic [ADDRESS_WIDTH:0] used;
    logic [ADDRESS_WIDTH:0] level;
    logic [DATA_WIDTH-1:0]  dout_q;
    logic                   overflow_q;
    logic                   underflow_q;
    logic                   full_c;
    logic                   empty_c;
    logic                   wr_ok;
    logic                   rd_ok;

    always_comb begin
        used    = wr_ptr - mk_ptr;
        level   = wr_ptr - rd_ptr;
        full_c  = (used == DEPTH_P);
        empty_c = (wr_ptr == rd_ptr);
        wr_ok   = bus.wr_en && !full_c;
        rd_ok   = bus.rd_en && !empty_c && !bus.rewind;
        // mark captures the read pointer as it will stand after this edge
        rd_next = rd_ptr + {{ADDRESS_WIDTH{1'b0}}, rd_ok};
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[ADDRESS_WIDTH-1:0]] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mk_ptr      <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (bus.wr_en && full_c) begin
                overflow_q <= 1'b1;
            end
            if (bus.rewind) begin
                rd_ptr <= mk_ptr;
            end else begin
                if (rd_ok) begin
                    dout_q <= mem[rd_ptr[ADDRESS_WIDTH-1:0]];
                    rd_ptr <= rd_next;
                end
                if (bus.rd_en && empty_c) begin
                    underflow_q <= 1'b1;
                end
                if (bus.mark) begin
                    mk_ptr <= rd_next;
                end
            end
        end
    end

    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.count        = level;
    assign bus.almost_full  = (used >= AF_THRESH);
    assign bus.almost_empty = (level <= AE_THRESH);
    assign bus.dout         = dout_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sfifo_mark.sv
// Bench for sfifo_mark: directed scenarios plus random traffic, all checked
// against a queue-based model of committed/replayable data.
module tb_sfifo_mark;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sfifo_mark_if #(.DATA_WIDTH(9), .ADDRESS_WIDTH(4)) bif ();

    sfifo_mark #(
        .DATA_WIDTH(9),
        .ADDRESS_WIDTH(4),
        .AF_MARGIN(4),
        .AE_LEVEL(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bif)
    );

    // Model: buffer holds every word from the mark onward; rd_off counts
    // words already read past the mark.
    logic [8:0] mbuf[$];
    int         rd_off;
    logic [8:0] m_dout;
    logic       m_of;
    logic       m_uf;

    int passes = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        int cnt;
        cnt = mbuf.size() - rd_off;
        check({tag, ".full"},  32'(bif.full),         32'(mbuf.size() == 16));
        check({tag, ".empty"}, 32'(bif.empty),        32'(cnt == 0));
        check({tag, ".count"}, 32'(bif.count),        32'(cnt));
        check({tag, ".af"},    32'(bif.almost_full),  32'(mbuf.size() >= 12));
        check({tag, ".ae"},    32'(bif.almost_empty), 32'(cnt <= 4));
        check({tag, ".dout"},  32'(bif.dout),         32'(m_dout));
        check({tag, ".ovf"},   32'(bif.overflow),     32'(m_of));
        check({tag, ".udf"},   32'(bif.underflow),    32'(m_uf));
    endtask

    task automatic model_reset();
        mbuf.delete();
        rd_off = 0;
        m_dout = '0;
        m_of   = 1'b0;
        m_uf   = 1'b0;
    endtask

    task automatic model_step(input logic w, input logic [8:0] d, input logic r,
                              input logic m, input logic rw);
        logic was_full, was_empty;
        was_full  = (mbuf.size() == 16);
        was_empty = (mbuf.size() == rd_off);
        if (rw) begin
            rd_off = 0;
        end else begin
            if (r && !was_empty) begin
                m_dout = mbuf[rd_off];
                rd_off++;
            end
            if (r && was_empty) m_uf = 1'b1;
            if (m) begin
                repeat (rd_off) void'(mbuf.pop_front());
                rd_off = 0;
            end
        end
        if (w && !was_full) mbuf.push_back(d);
        if (w && was_full) m_of = 1'b1;
    endtask

    // One clock: drive at negedge, model at posedge, check at next negedge.
    task automatic cyc(input string tag, input logic w, input logic [8:0] d,
                       input logic r, input logic m, input logic rw);
        bif.wr_en  = w;
        bif.din    = d;
        bif.rd_en  = r;
        bif.mark   = m;
        bif.rewind = rw;
        @(posedge clk);
        model_step(w, d, r, m, rw);
        @(negedge clk);
        bif.wr_en = 1'b0; bif.rd_en = 1'b0; bif.mark = 1'b0; bif.rewind = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        bif.wr_en = 1'b0; bif.rd_en = 1'b0; bif.mark = 1'b0; bif.rewind = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        bif.din = '0; bif.wr_en = 1'b0; bif.rd_en = 1'b0;
        bif.mark = 1'b0; bif.rewind = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset("reset");
        check("reset_empty_const", 32'(bif.empty), 32'd1);

        // Fill and drain with mark on every read
        for (int i = 0; i < 16; i++) begin
            cyc("fill", 1'b1, 9'(9'h100 + i), 1'b0, 1'b0, 1'b0);
            if (i == 11) check("af_at_12", 32'(bif.almost_full), 32'd1);
        end
        check("full_after_16", 32'(bif.full), 32'd1);
        check("count_16", 32'(bif.count), 32'd16);
        cyc("write17", 1'b1, 9'h055, 1'b0, 1'b0, 1'b0);
        check("overflow_set", 32'(bif.overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            cyc("drain", 1'b0, '0, 1'b1, 1'b1, 1'b0);
            check("drain_data", 32'(bif.dout), 32'(9'h100 + i));
        end
        cyc("extra_read", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("underflow_set", 32'(bif.underflow), 32'd1);
        check("dout_hold", 32'(bif.dout), 32'h10F);

        // Replay from the last mark
        do_reset("reset2");
        for (int i = 0; i < 8; i++) cyc("rp_wr", 1'b1, 9'(9'h0A0 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc("rp_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("rp_dout", 32'(bif.dout), 32'h0A4);
        check("rp_count3", 32'(bif.count), 32'd3);
        cyc("rp_rewind", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("rp_count8", 32'(bif.count), 32'd8);
        cyc("rp_reread", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("rp_first", 32'(bif.dout), 32'h0A0);

        // Mark frees space
        do_reset("reset3");
        for (int i = 0; i < 16; i++) cyc("mf_wr", 1'b1, 9'(i), 1'b0, 1'b0, 1'b0);
        cyc("mf_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc("mf_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("mf_still_full", 32'(bif.full), 32'd1);
        cyc("mf_rdmark", 1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("mf_not_full", 32'(bif.full), 32'd0);
        for (int i = 0; i < 3; i++) cyc("mf_refill", 1'b1, 9'(9'h1E0 + i), 1'b0, 1'b0, 1'b0);
        check("mf_no_ovf", 32'(bif.overflow), 32'd0);
        cyc("mf_4th", 1'b1, 9'h1EE, 1'b0, 1'b0, 1'b0);
        check("mf_ovf", 32'(bif.overflow), 32'd1);

        // Collisions
        do_reset("reset4");
        for (int i = 0; i < 16; i++) cyc("co_wr", 1'b1, 9'(9'h040 + i), 1'b0, 1'b0, 1'b0);
        cyc("co_rd", 1'b0, '0, 1'b1, 1'b1, 1'b0);
        cyc("co_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc("co_rd_rew", 1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("co_rew_dout", 32'(bif.dout), 32'h041);
        check("co_rew_count", 32'(bif.count), 32'd15);
        cyc("co_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc("co_mark_rew", 1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("co_mk_kept", 32'(bif.count), 32'd15);
        cyc("co_wr_fill", 1'b1, 9'h07F, 1'b0, 1'b0, 1'b0);
        cyc("co_wr_rd_full", 1'b1, 9'h033, 1'b1, 1'b0, 1'b0);
        check("co_full_count", 32'(bif.count), 32'd15);
        check("co_full_ovf", 32'(bif.overflow), 32'd1);

        // Mid-operation reset
        do_reset("reset5");
        for (int i = 0; i < 16; i++) cyc("mr_wr", 1'b1, 9'(i), 1'b0, 1'b0, 1'b0);
        cyc("mr_ovf", 1'b1, 9'h1AA, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cyc("mr_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("mr_count7", 32'(bif.count), 32'd7);
        do_reset("mid_reset");
        check("mr_ovf_clr", 32'(bif.overflow), 32'd0);
        check("mr_dout0", 32'(bif.dout), 32'd0);
        cyc("mr_wr1ff", 1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0);
        cyc("mr_rd1ff", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("mr_data", 32'(bif.dout), 32'h1FF);

        // Random traffic
        do_reset("reset6");
        for (int i = 0; i < 600; i++) begin
            cyc("rand",
                1'($urandom_range(0, 99) < 55),
                9'($urandom_range(0, 511)),
                1'($urandom_range(0, 99) < 50),
                1'($urandom_range(0, 99) < 30),
                1'($urandom_range(0, 99) < 5));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
